// File: rtl/alu_seq.sv
// alu_seq: parametrised sequential ALU, ops 0-7 single-cycle, iterative MUL, optional DIV (macro ALU_SEQ_DIV_EN).
// Latency: 1 cycle for ops 0-7, reserved ops and DIV by zero; WIDTH+1 cycles for MUL and DIV.
// Backpressure: in_ready low while iterating or while a result is held against out_ready=0.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             lt,
    output logic             eq,
    output logic             dz,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_SHIFT = 4'd3;
    localparam logic [3:0] OP_NEG   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_COMP  = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OP_DIV   = 4'd9;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;
`else
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
`endif

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier shifting out, product low half / quotient
    logic [WIDTH-1:0] opnd;     // captured multiplicand / divisor

    logic accept, last_iter, start_mul, start_mc;

    logic [WIDTH-1:0] res_c;
    logic             ov_c, lt_c, eq_c, dz_c;
    logic [WIDTH-1:0] sum, diff, neg;
    logic [SHW-1:0]   sh_s, sh_mag;

    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;

    assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign busy      = (state != S_IDLE);
    assign start_mul = accept && (op == OP_MUL);

    // One shift-add step: conditionally add the multiplicand into the high half, then shift right.
    assign mul_add = acc_lo[0] ? opnd : '0;
    assign mul_sum = {1'b0, acc_hi} + {1'b0, mul_add};
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    logic             start_div, div_ge;
    logic [WIDTH:0]   div_rs;
    logic [WIDTH-1:0] div_r, div_q;

    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    assign start_div = accept && (op == OP_DIV) && (b != '0);
    assign div_rs    = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_rs >= {1'b0, opnd});
    assign div_r     = div_ge ? WIDTH'(div_rs - {1'b0, opnd}) : div_rs[WIDTH-1:0];
    assign div_q     = {acc_lo[WIDTH-2:0], div_ge};
    assign start_mc  = start_mul || start_div;
`else
    assign start_mc  = start_mul;
`endif

    // Single-cycle result and flags for the operation currently presented on a/b/op.
    always_comb begin
        res_c  = '0;
        ov_c   = 1'b0;
        lt_c   = 1'b0;
        eq_c   = 1'b0;
        dz_c   = 1'b0;
        sum    = a + b;
        diff   = a - b;
        neg    = '0 - b;
        sh_s   = b[SHW-1:0];
        sh_mag = sh_s[SHW-1] ? (~sh_s + 1'b1) : sh_s;
        case (op)
            OP_ADD: begin
                res_c = sum;
                ov_c  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                res_c = diff;
                ov_c  = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_NEG: begin
                res_c = neg;
                ov_c  = (b == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_AND: res_c = a & b;
            OP_OR:  res_c = a | b;
            OP_NOT: res_c = ~b;
            OP_SHIFT: begin
                // Negative amounts shift right logically; the most negative code is >= WIDTH too.
                if (sh_mag >= SHW'(WIDTH))
                    res_c = '0;
                else if (sh_s[SHW-1])
                    res_c = a >> sh_mag;
                else
                    res_c = a << sh_mag;
            end
            OP_COMP: begin
                lt_c  = ($signed(a) < $signed(b));
                eq_c  = (a == b);
                res_c = {{(WIDTH-2){1'b0}}, lt_c, eq_c};
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                // Only the divide-by-zero case retires from here; other divides iterate.
                if (b == '0) begin
                    res_c = '1;
                    dz_c  = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next state: leave IDLE only for iterative ops, return after the last iteration.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_mul)
                    state_nxt = S_MUL;
`ifdef ALU_SEQ_DIV_EN
                else if (start_div)
                    state_nxt = S_DIV;
`endif
            end
            S_MUL: if (last_iter) state_nxt = S_IDLE;
`ifdef ALU_SEQ_DIV_EN
            S_DIV: if (last_iter) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture at accept, iteration steps, and the output register set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            dz        <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= '0;
                if (start_mc) begin
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= 1'b1;
                    result    <= res_c;
                    overflow  <= ov_c;
                    lt        <= lt_c;
                    eq        <= eq_c;
                    dz        <= dz_c;
                end
                if (start_mul) begin
                    acc_hi <= '0;
                    acc_lo <= b;
                    opnd   <= a;
                end
`ifdef ALU_SEQ_DIV_EN
                if (start_div) begin
                    acc_hi <= '0;
                    acc_lo <= a;
                    opnd   <= b;
                end
`endif
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == S_MUL) begin
                cnt    <= cnt + CW'(1);
                acc_hi <= mul_hi;
                acc_lo <= mul_lo;
                if (last_iter) begin
                    out_valid <= 1'b1;
                    result    <= mul_lo;
                    overflow  <= |mul_hi;
                    lt        <= 1'b0;
                    eq        <= 1'b0;
                    dz        <= 1'b0;
                end
            end
`ifdef ALU_SEQ_DIV_EN
            if (state == S_DIV) begin
                cnt    <= cnt + CW'(1);
                acc_hi <= div_r;
                acc_lo <= div_q;
                if (last_iter) begin
                    out_valid <= 1'b1;
                    result    <= div_q;
                    overflow  <= 1'b0;
                    lt        <= 1'b0;
                    eq        <= 1'b0;
                    dz        <= 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven vectors through a scoreboard, plus hand-written MUL, hold and reset sequences.
// Expected results are queued at accept and compared when the DUT retires a result.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_alu_seq;
    localparam int WIDTH = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ov;
        logic        lt;
        logic        eq;
        logic        dz;
        int          lat;   // 0 = latency not checked
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } sb_t;

    logic              clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0]  a, b, result;
    logic [3:0]        op;
    logic              overflow, lt, eq, dz, busy;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    vec_t vecs[$];
    sb_t  sb[$];
    sb_t  e;

    alu_seq #(.WIDTH(WIDTH), .SHW(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .lt(lt), .eq(eq), .dz(dz), .busy(busy)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Cycle counter for latency measurement.
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v, input bit push);
        int g = 0;
        op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
        while (!in_ready && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=%0b want 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) sb.push_back('{v: v, acc: cyc});
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
    endtask

    // Scoreboard: every retiring result is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_output: got result %h, want no output", result);
            end else begin
                e = sb.pop_front();
                chk($sformatf("op%0d_result", e.v.op), result, e.v.res);
                chk($sformatf("op%0d_flags", e.v.op), {overflow, lt, eq, dz},
                    {e.v.ov, e.v.lt, e.v.eq, e.v.dz});
                if (e.v.lat != 0)
                    chk($sformatf("op%0d_latency", e.v.op), cyc - e.acc + 1, e.v.lat);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t mulv, addv;
        bit   ok;
        clk = 0; rst_n = 0; in_valid = 0; a = '0; b = '0; op = '0; out_ready = 1;

        //          op     a             b             result        ov    lt    eq    dz    lat
        vecs.push_back('{4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd6, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd2, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd5, 32'h00000001, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd4, 32'h00000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd4, 32'h00000000, 32'h00000005, 32'hFFFFFFFB, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd7, 32'hFFFFFFFF, 32'h00000001, 32'h00000002, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd7, 32'h00001234, 32'h00001234, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'd7, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd3, 32'h00000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd3, 32'h80000000, 32'h0000003F, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd3, 32'h00000001, 32'h00000020, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd3, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd3, 32'h80000000, 32'h00000021, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd3, 32'h000000F0, 32'h0000003C, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd3, 32'h00000003, 32'h00000104, 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd8, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 33});
        vecs.push_back('{4'd8, 32'h00001234, 32'h00005678, 32'h06260060, 1'b0, 1'b0, 1'b0, 1'b0, 33});
        vecs.push_back('{4'd8, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 33});
        vecs.push_back('{4'd0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0, 1});
`ifdef ALU_SEQ_DIV_EN
        vecs.push_back('{4'd9, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 1'b0, 1'b0, 1'b0, 33});
        vecs.push_back('{4'd9, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{4'd9, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 33});
        vecs.push_back('{4'd9, 32'h00000007, 32'h00000064, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 33});
`else
        vecs.push_back('{4'd9, 32'h00000064, 32'h00000007, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd9, 32'h00000009, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
`endif

        // Reset state.
        #12;
        chk("reset_result", result, 0);
        chk("reset_ctrl", {out_valid, overflow, lt, eq, dz, busy}, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 1);

        // Table vectors, issued back to back.
        for (int i = 0; i < vecs.size(); i++) send(vecs[i], 1'b1);
        wait_drain();

        // MUL: busy high and in_ready low for every iteration cycle.
        mulv = '{4'd8, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 33};
        send(mulv, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
        end
        chk("mul_busy_no_ready", ok, 1);
        wait_drain();

        // Output hold: result held stable against out_ready=0 for 5 cycles.
        out_ready = 0;
        addv = '{4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        send(addv, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h80000000 ||
                overflow !== 1'b1) ok = 1'b0;
        end
        chk("hold_stable", ok, 1);
        @(posedge clk);
        #1;
        out_ready = 1;
        wait_drain();

        // Reset mid-MUL: outputs clear at once and the aborted op never emits.
        send(mulv, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_mul_busy", busy, 1);
        rst_n = 0;
        #1;
        chk("rst_result", result, 0);
        chk("rst_ctrl", {out_valid, overflow, lt, eq, dz, busy}, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {in_ready, busy}, 2'b10);
        repeat (WIDTH + 5) @(posedge clk);
        #1;
        chk("post_rst_no_output", out_valid, 0);

        // Throughput after reset: two single-cycle ops still retire correctly.
        send(vecs[0], 1'b1);
        send(vecs[2], 1'b1);
        wait_drain();
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
